// File: rtl/pc_next_unit.sv
// Fetch-stage PC register with sequential/branch/jalr targets and a one-entry redirect buffer that holds a redirect across stall.
// Redirects land on pc one cycle later (or one cycle after stall drops); PC_MISALIGN_TRAP_EN rejects targets with bit1 set.
module pc_next_unit #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] INC          = WIDTH'(4)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] rs1,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus_inc,
  output logic [WIDTH-1:0] target,
  output logic             redirect_pending,
  output logic             misalign
);

  typedef enum logic [1:0] {
    SEL_SEQ  = 2'b00,
    SEL_BR   = 2'b01,
    SEL_JALR = 2'b10,
    SEL_HOLD = 2'b11
  } sel_t;

  sel_t             sel_mode;
  logic [WIDTH-1:0] br_tgt;
  logic [WIDTH-1:0] jalr_sum;
  logic [WIDTH-1:0] jalr_tgt;
  logic [WIDTH-1:0] pending_target;
  logic             is_redirect;
  logic             tgt_bad;

  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] pending_target_d;
  logic             redirect_pending_d;
  logic             misalign_d;

  assign sel_mode    = sel_t'(sel);
  assign pc_plus_inc = pc + INC;
  assign br_tgt      = pc + imm;
  assign jalr_sum    = rs1 + imm;
  // bit0 is cleared after the add, not on the operands
  assign jalr_tgt    = {jalr_sum[WIDTH-1:1], 1'b0};
  assign is_redirect = (sel_mode == SEL_BR) || (sel_mode == SEL_JALR);

  always_comb begin
    target = pc_plus_inc;
    case (sel_mode)
      SEL_BR:   target = br_tgt;
      SEL_JALR: target = jalr_tgt;
      default:  target = pc_plus_inc;
    endcase
  end

`ifdef PC_MISALIGN_TRAP_EN
  assign tgt_bad = is_redirect && target[1];
`else
  assign tgt_bad = 1'b0;
`endif

  always_comb begin
    pc_d               = pc;
    pending_target_d   = pending_target;
    redirect_pending_d = redirect_pending;
    misalign_d         = 1'b0;
    if (stall) begin
      if (is_redirect) begin
        if (tgt_bad) begin
          misalign_d = 1'b1;
        end else begin
          // latest redirect overwrites any older buffered one
          pending_target_d   = target;
          redirect_pending_d = 1'b1;
        end
      end
    end else if (redirect_pending) begin
      // buffered redirect belongs to an older instruction, so sel is ignored
      pc_d               = pending_target;
      redirect_pending_d = 1'b0;
    end else begin
      case (sel_mode)
        SEL_SEQ:  pc_d = pc_plus_inc;
        SEL_BR,
        SEL_JALR: begin
          if (tgt_bad) misalign_d = 1'b1;
          else         pc_d = target;
        end
        default:  pc_d = pc;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc               <= RESET_VECTOR;
      pending_target   <= '0;
      redirect_pending <= 1'b0;
    end else begin
      pc               <= pc_d;
      pending_target   <= pending_target_d;
      redirect_pending <= redirect_pending_d;
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (reset) misalign <= 1'b0;
    else       misalign <= misalign_d;
  end
`else
  assign misalign = 1'b0;
  logic unused_misalign_d;
  assign unused_misalign_d = misalign_d;
`endif

endmodule

// File: tb/tb_pc_next_unit.sv
// Table-driven bench for pc_next_unit: each row is one cycle of stimulus with the state expected after the edge.
module tb_pc_next_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [1:0]  sel;
  logic [31:0] imm;
  logic [31:0] rs1;
  logic [31:0] pc;
  logic [31:0] pc_plus_inc;
  logic [31:0] target;
  logic        redirect_pending;
  logic        misalign;

  pc_next_unit #(.WIDTH(32), .RESET_VECTOR(32'h0), .INC(32'h4)) dut (
    .clk(clk), .reset(reset), .stall(stall), .sel(sel), .imm(imm), .rs1(rs1),
    .pc(pc), .pc_plus_inc(pc_plus_inc), .target(target),
    .redirect_pending(redirect_pending), .misalign(misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stl;
    logic [1:0]  s;
    logic [31:0] im;
    logic [31:0] r1;
    logic [31:0] exp_tgt;
    logic [31:0] exp_pc;
    logic        exp_pend;
    logic        exp_mis;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] pc;
    logic        pend;
    logic        mis;
  } exp_t;

  localparam int NV = 29;
  vec_t vecs[NV];
  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check32(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s row %0d: got %h, expected %h", name, idx, act, req);
    end
  endtask

  task automatic check1(input string name, input int idx, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s row %0d: got %b, expected %b", name, idx, act, req);
    end
  endtask

  initial begin
    //          rst   stl   sel    imm           rs1           target        pc            pend  mis
    vecs[0]  = '{1'b1, 1'b0, 2'b00, 32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 2'b00, 32'h0,        32'h0,        32'h4,        32'h4,        1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 2'b00, 32'h0,        32'h0,        32'h8,        32'h8,        1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 2'b00, 32'h0,        32'h0,        32'hC,        32'hC,        1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 2'b01, 32'hF4,       32'h0,        32'h100,      32'h100,      1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 2'b01, 32'hFFFFFFF0, 32'h0,        32'hF0,       32'hF0,       1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 2'b10, 32'h0,        32'h2001,     32'h2000,     32'h2000,     1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 2'b11, 32'h0,        32'h0,        32'h2004,     32'h2000,     1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 2'b10, 32'h0,        32'h40,       32'h40,       32'h40,       1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 2'b01, 32'h20,       32'h0,        32'h60,       32'h40,       1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 2'b00, 32'h0,        32'h0,        32'h44,       32'h40,       1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 2'b00, 32'h0,        32'h0,        32'h44,       32'h40,       1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 2'b00, 32'h0,        32'h0,        32'h44,       32'h60,       1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 2'b10, 32'h0,        32'h80,       32'h80,       32'h60,       1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 2'b01, 32'h1A0,      32'h0,        32'h200,      32'h60,       1'b1, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 2'b01, 32'h1000,     32'h0,        32'h1060,     32'h200,      1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 2'b00, 32'h0,        32'h0,        32'h204,      32'h204,      1'b0, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 2'b11, 32'h0,        32'h0,        32'h208,      32'h204,      1'b0, 1'b0};
    vecs[18] = '{1'b0, 1'b0, 2'b10, 32'h0,        32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFFFFFFFC, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 1'b0, 2'b00, 32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 1'b0};
    vecs[20] = '{1'b0, 1'b0, 2'b10, 32'hFFFFFFFF, 32'h1005,     32'h1004,     32'h1004,     1'b0, 1'b0};
    vecs[21] = '{1'b0, 1'b1, 2'b01, 32'h100,      32'h0,        32'h1104,     32'h1004,     1'b1, 1'b0};
    vecs[22] = '{1'b1, 1'b1, 2'b01, 32'h100,      32'h0,        32'h1104,     32'h0,        1'b0, 1'b0};
    vecs[23] = '{1'b0, 1'b0, 2'b00, 32'h0,        32'h0,        32'h4,        32'h4,        1'b0, 1'b0};
    vecs[24] = '{1'b0, 1'b0, 2'b01, 32'hC,        32'h0,        32'h10,       32'h10,       1'b0, 1'b0};
`ifdef PC_MISALIGN_TRAP_EN
    vecs[25] = '{1'b0, 1'b0, 2'b01, 32'h2,        32'h0,        32'h12,       32'h10,       1'b0, 1'b1};
    vecs[26] = '{1'b0, 1'b0, 2'b00, 32'h0,        32'h0,        32'h14,       32'h14,       1'b0, 1'b0};
    vecs[27] = '{1'b0, 1'b1, 2'b01, 32'h2,        32'h0,        32'h16,       32'h14,       1'b0, 1'b1};
    vecs[28] = '{1'b0, 1'b0, 2'b00, 32'h0,        32'h0,        32'h18,       32'h18,       1'b0, 1'b0};
`else
    vecs[25] = '{1'b0, 1'b0, 2'b01, 32'h2,        32'h0,        32'h12,       32'h12,       1'b0, 1'b0};
    vecs[26] = '{1'b0, 1'b0, 2'b00, 32'h0,        32'h0,        32'h16,       32'h16,       1'b0, 1'b0};
    vecs[27] = '{1'b0, 1'b1, 2'b01, 32'h2,        32'h0,        32'h18,       32'h16,       1'b1, 1'b0};
    vecs[28] = '{1'b0, 1'b0, 2'b00, 32'h0,        32'h0,        32'h1A,       32'h18,       1'b0, 1'b0};
`endif

    reset = 1'b1; stall = 1'b0; sel = 2'b00; imm = '0; rs1 = '0;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      exp_t e;
      reset = vecs[i].rst;
      stall = vecs[i].stl;
      sel   = vecs[i].s;
      imm   = vecs[i].im;
      rs1   = vecs[i].r1;
      #1;
      // combinational outputs follow the registered pc and current inputs
      if (i > 0) begin
        check32("target", i, target, vecs[i].exp_tgt);
        check32("pc_plus_inc", i, pc_plus_inc, vecs[i-1].exp_pc + 32'h4);
      end
      e.idx  = i;
      e.pc   = vecs[i].exp_pc;
      e.pend = vecs[i].exp_pend;
      e.mis  = vecs[i].exp_mis;
      sb.push_back(e);
      @(posedge clk); #1;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard row %0d: got empty queue, expected one entry", i);
      end else begin
        exp_t x;
        x = sb.pop_front();
        check32("pc", x.idx, pc, x.pc);
        check1("redirect_pending", x.idx, redirect_pending, x.pend);
        check1("misalign", x.idx, misalign, x.mis);
      end
    end

    // misalign must drop after its single cycle even with no further redirects
    stall = 1'b0; sel = 2'b11; reset = 1'b0;
    @(posedge clk); #1;
    check1("misalign_clear", NV, misalign, 1'b0);
    check32("hold_pc", NV, pc, 32'h18);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
